alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_bcd_nibble.sv | 26 ++
 rtl/alu_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcodes, flag indices, FSM states and op-class helpers for alu_seq
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_DADD = 4'd5,
    OP_BIT  = 4'd6,
    OP_BIC  = 4'd7,
    OP_BIS  = 4'd8,
    OP_XOR  = 4'd9,
    OP_AND  = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DADD = 2'd2
  } state_e;

  function automatic logic OP_WRITES(input logic [3:0] op);
    return !(op == OP_CMP || op == OP_BIT || op > OP_MUL);
  endfunction

  function automatic logic OP_SETS_FLAGS(input logic [3:0] op);
    return (op <= OP_BIT) || (op == OP_XOR) || (op == OP_AND);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bcd_nibble.sv
// ============================================================================
//  Module      : alu_bcd_nibble
//  Description : Combinational single-digit BCD adder with decimal carry
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_bcd_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_raw;

  always_comb begin
    w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout  = (w_raw > 5'd9);
    sum   = cout ? 4'(w_raw + 5'd6) : w_raw[3:0];
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Registered MSP430-style ALU with flag state, serial MUL and DADD
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [3:0]       op,
  input  logic             byte_mode,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic             flags_we,
  input  logic [3:0]       flags_in,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             wr_en,
  output logic [3:0]       flags,
  output logic             done,
  output logic             illegal
);

  localparam int   CW      = $clog2(WIDTH + 1);
  localparam logic HAS_MUL = (MUL_EN != 0);

  state_e             r_state, w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result, r_result_hi;
  logic [3:0]         r_flags;
  logic               r_done, r_wr_en, r_illegal, r_byte;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier, r_da, r_db, r_dsum;
  logic               r_dcy;

  logic               w_accept, w_illegal_op, w_mul_go, w_dadd_go, w_cin, w_cout, w_last;
  logic [WIDTH-1:0]   w_mask, w_a, w_b, w_opb, w_res;
  logic [WIDTH:0]     w_sum;
  logic [3:0]         w_fl, w_nsum;
  logic               w_ncout;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_dsum_next, w_dadd_res;

  function automatic logic msb_of(input logic [WIDTH-1:0] x, input logic bm);
    return bm ? x[7] : x[WIDTH-1];
  endfunction

  assign w_accept     = start && ready;
  assign w_illegal_op = (op > OP_MUL) || (op == OP_MUL && !HAS_MUL);
  assign w_mul_go     = w_accept && (op == OP_MUL) && HAS_MUL;
  assign w_dadd_go    = w_accept && (op == OP_DADD);
  assign w_last       = (r_cnt == CW'(1));
  assign w_mask       = byte_mode ? WIDTH'(8'hFF) : '1;
  assign w_a          = dst & w_mask;
  assign w_b          = src & w_mask;

  // Subtraction shares the adder: dst + ~src + (1 or C)
  always_comb begin
    w_opb = w_b;
    w_cin = 1'b0;
    case (op)
      OP_ADDC:        w_cin = r_flags[FLAG_C];
      OP_SUB, OP_CMP: begin w_opb = ~src & w_mask; w_cin = 1'b1; end
      OP_SUBC:        begin w_opb = ~src & w_mask; w_cin = r_flags[FLAG_C]; end
      default:        ;
    endcase
    w_sum  = {1'b0, w_a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
    w_cout = byte_mode ? w_sum[8] : w_sum[WIDTH];
  end

  always_comb begin
    w_res = '0;
    w_fl  = r_flags;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        w_res         = w_sum[WIDTH-1:0] & w_mask;
        w_fl[FLAG_N]  = msb_of(w_res, byte_mode);
        w_fl[FLAG_Z]  = (w_res == '0);
        w_fl[FLAG_C]  = w_cout;
        w_fl[FLAG_V]  = (msb_of(w_a, byte_mode) == msb_of(w_opb, byte_mode)) &&
                        (msb_of(w_res, byte_mode) != msb_of(w_a, byte_mode));
      end
      OP_BIT, OP_AND, OP_XOR: begin
        w_res         = (op == OP_XOR) ? (w_a ^ w_b) : (w_a & w_b);
        w_fl[FLAG_N]  = msb_of(w_res, byte_mode);
        w_fl[FLAG_Z]  = (w_res == '0);
        w_fl[FLAG_C]  = (w_res != '0);
        w_fl[FLAG_V]  = (op == OP_XOR) && msb_of(w_a, byte_mode) && msb_of(w_b, byte_mode);
      end
      OP_BIC:  w_res = ~src & dst & w_mask;
      OP_BIS:  w_res = (src | dst) & w_mask;
      default: ;
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  alu_bcd_nibble u_bcd (
    .a    (r_da[3:0]),
    .b    (r_db[3:0]),
    .cin  (r_dcy),
    .sum  (w_nsum),
    .cout (w_ncout)
  );

  // Digits enter at the top; a byte op leaves its two digits in the top byte
  assign w_dsum_next = {w_nsum, r_dsum[WIDTH-1:4]};
  assign w_dadd_res  = r_byte ? (w_dsum_next >> (WIDTH - 8)) : w_dsum_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mul_go)       w_state_next = ST_MUL;
        else if (w_dadd_go) w_state_next = ST_DADD;
      end
      ST_MUL, ST_DADD: if (w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == ST_IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
      r_done      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_illegal   <= 1'b0;
      r_byte      <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_da        <= '0;
      r_db        <= '0;
      r_dsum      <= '0;
      r_dcy       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_illegal <= 1'b0;
      if (flags_we) r_flags <= flags_in;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_byte <= byte_mode;
          if (w_mul_go) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_a};
            r_mplier <= w_b;
            r_cnt    <= byte_mode ? CW'(8) : CW'(WIDTH);
          end else if (w_dadd_go) begin
            r_da   <= w_a;
            r_db   <= w_b;
            r_dsum <= '0;
            r_dcy  <= r_flags[FLAG_C];
            r_cnt  <= byte_mode ? CW'(2) : CW'(WIDTH / 4);
          end else begin
            r_done      <= 1'b1;
            r_illegal   <= w_illegal_op;
            r_wr_en     <= !w_illegal_op && OP_WRITES(op);
            r_result    <= w_illegal_op ? '0 : w_res;
            r_result_hi <= '0;
            if (!w_illegal_op && OP_SETS_FLAGS(op)) r_flags <= w_fl;
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (w_last) begin
            r_done      <= 1'b1;
            r_wr_en     <= 1'b1;
            r_result    <= r_byte ? WIDTH'(w_acc_next[7:0])  : w_acc_next[WIDTH-1:0];
            r_result_hi <= r_byte ? WIDTH'(w_acc_next[15:8]) : w_acc_next[2*WIDTH-1:WIDTH];
          end
        end
        ST_DADD: begin
          r_da   <= r_da >> 4;
          r_db   <= r_db >> 4;
          r_dsum <= w_dsum_next;
          r_dcy  <= w_ncout;
          r_cnt  <= r_cnt - CW'(1);
          if (w_last) begin
            r_done      <= 1'b1;
            r_wr_en     <= 1'b1;
            r_result    <= w_dadd_res;
            r_result_hi <= '0;
            r_flags     <= {msb_of(w_dadd_res, r_byte), (w_dadd_res == '0), w_ncout, 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign flags     = r_flags;
  assign done      = r_done;
  assign wr_en     = r_wr_en;
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Scoreboard bench for alu_seq (timing, flags, serial ops, reset)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, byte_mode = 1'b0, flags_we = 1'b0;
  logic [3:0]  op = 4'd0, flags_in = 4'd0;
  logic [15:0] src = 16'd0, dst = 16'd0;
  logic        ready, wr_en, done, illegal;
  logic [15:0] result, result_hi;
  logic [3:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  fl;
    logic        wr;
    logic        ill;
    logic        cr;
  } exp_t;
  exp_t sb[$];

  alu_seq #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .op        (op),
    .byte_mode (byte_mode),
    .src       (src),
    .dst       (dst),
    .flags_we  (flags_we),
    .flags_in  (flags_in),
    .result    (result),
    .result_hi (result_hi),
    .wr_en     (wr_en),
    .flags     (flags),
    .done      (done),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: done=1 result=%h with nothing expected", result);
      end else begin
        e = sb.pop_front();
        if (result_hi !== e.hi || flags !== e.fl || wr_en !== e.wr ||
            illegal !== e.ill || (e.cr && result !== e.res)) begin
          n_fail++;
          $display("FAIL sb_%s: got result=%h hi=%h flags=%b wr_en=%b illegal=%b, want result=%h hi=%h flags=%b wr_en=%b illegal=%b",
                   e.name, result, result_hi, flags, wr_en, illegal, e.res, e.hi, e.fl, e.wr, e.ill);
        end
      end
    end
  end

  function automatic void push(input string nm, input logic [15:0] r, input logic [15:0] h,
                               input logic [3:0] f, input logic w, input logic il, input logic cr);
    exp_t e;
    e.name = nm; e.res = r; e.hi = h; e.fl = f; e.wr = w; e.ill = il; e.cr = cr;
    sb.push_back(e);
  endfunction

  task automatic send(input logic [3:0] o, input logic bm, input logic [15:0] s, input logic [15:0] d);
    @(negedge clk);
    start = 1'b1; op = o; byte_mode = bm; src = s; dst = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ready !== 1'b0 || done !== 1'b0 || result !== 16'h0 || result_hi !== 16'h0 ||
        flags !== 4'h0 || wr_en !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b done=%b result=%h hi=%h flags=%b wr=%b ill=%b, want all 0",
               ready, done, result, result_hi, flags, wr_en, illegal);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b want 1", ready);
    end
  endtask

  task automatic test_add_overflow;
    push("add_ovf", 16'h8000, 16'h0, 4'b1001, 1'b1, 1'b0, 1'b1);
    send(OP_ADD, 1'b0, 16'h0001, 16'h7FFF);
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_latency: done=%b ready=%b want 1 1", done, ready);
    end
  endtask

  task automatic test_carry_chain;
    push("add_carry", 16'h0000, 16'h0, 4'b0110, 1'b1, 1'b0, 1'b1);
    send(OP_ADD, 1'b0, 16'h0001, 16'hFFFF);
    push("addc_carry", 16'h0001, 16'h0, 4'b0000, 1'b1, 1'b0, 1'b1);
    send(OP_ADDC, 1'b0, 16'h0000, 16'h0000);
    n_tests++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_add_done: done=%b ready=%b want 1 1", done, ready);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_byte_sub;
    push("byte_sub", 16'h00FF, 16'h0, 4'b1000, 1'b1, 1'b0, 1'b1);
    send(OP_SUB, 1'b1, 16'h0001, 16'h1200);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_dadd;
    @(negedge clk);
    flags_we = 1'b1; flags_in = 4'b0000;
    @(negedge clk);
    flags_we = 1'b0;
    n_tests++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL flags_we_write: flags=%b want 0000", flags);
    end
    push("dadd_word", 16'h1000, 16'h0, 4'b0000, 1'b1, 1'b0, 1'b1);
    send(OP_DADD, 1'b0, 16'h0001, 16'h0999);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      // Requests while busy must be dropped
      start = (i < 3); op = OP_ADD;
      n_tests++;
      if (ready !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL dadd_busy[%0d]: ready=%b done=%b want 0 0", i, ready, done);
      end
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dadd_done: done=%b ready=%b want 1 1", done, ready);
    end
  endtask

  task automatic test_mul;
    logic [15:0] s_tab[2] = '{16'h0100, 16'h3402};
    logic [15:0] d_tab[2] = '{16'h1234, 16'h12FF};
    logic [15:0] r_tab[2] = '{16'h3400, 16'h00FE};
    logic [15:0] h_tab[2] = '{16'h0012, 16'h0001};
    int          n_tab[2] = '{16, 8};
    for (int k = 0; k < 2; k++) begin
      push(k == 0 ? "mul_word" : "mul_byte", r_tab[k], h_tab[k], 4'b0000, 1'b1, 1'b0, 1'b1);
      send(OP_MUL, (k == 1), s_tab[k], d_tab[k]);
      for (int i = 0; i < n_tab[k]; i++) begin
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (ready !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL mul_busy[%0d][%0d]: ready=%b done=%b want 0 0", k, i, ready, done);
        end
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b1 || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_done[%0d]: done=%b ready=%b want 1 1", k, done, ready);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  o_tab[7] = '{OP_CMP, OP_BIT, OP_XOR, OP_BIC, OP_BIS, OP_AND, OP_SUBC};
    logic [15:0] s_tab[7] = '{16'h0007, 16'h0F0F, 16'h8000, 16'h00FF, 16'h0001, 16'hF0F0, 16'h0001};
    logic [15:0] d_tab[7] = '{16'h0005, 16'h00F0, 16'h8001, 16'hFFFF, 16'h1000, 16'hFF00, 16'h0010};
    logic [15:0] r_tab[7] = '{16'h0000, 16'h0000, 16'h0001, 16'hFF00, 16'h1001, 16'hF000, 16'h000F};
    logic [3:0]  f_tab[7] = '{4'b1000, 4'b0100, 4'b0011, 4'b0011, 4'b0011, 4'b1010, 4'b0010};
    logic        w_tab[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      push($sformatf("b2b_op%0d", o_tab[i]), r_tab[i], 16'h0, f_tab[i], w_tab[i], 1'b0, (i >= 2));
      send(o_tab[i], 1'b0, s_tab[i], d_tab[i]);
      n_tests++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: ready=%b want 1", i, ready);
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_illegal;
    push("illegal", 16'h0000, 16'h0, 4'b0010, 1'b0, 1'b1, 1'b1);
    send(4'hF, 1'b0, 16'h1111, 16'h2222);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_flag_priority;
    push("flag_prio", 16'h0002, 16'h0, 4'b0000, 1'b1, 1'b0, 1'b1);
    send(OP_ADD, 1'b0, 16'h0001, 16'h0001);
    flags_we = 1'b1; flags_in = 4'b1111;
    @(negedge clk);
    start = 1'b0; flags_we = 1'b0;
    n_tests++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL flag_priority: flags=%b want 0000", flags);
    end
  endtask

  task automatic test_reset_mid_mul;
    @(negedge clk);
    flags_we = 1'b1; flags_in = 4'b1111;
    @(negedge clk);
    flags_we = 1'b0;
    send(OP_MUL, 1'b0, 16'h00FF, 16'h00FF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b0 || done !== 1'b0 || result !== 16'h0 || result_hi !== 16'h0 ||
        flags !== 4'h0 || wr_en !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_mul_reset: ready=%b done=%b result=%h hi=%h flags=%b wr=%b ill=%b, want all 0",
               ready, done, result, result_hi, flags, wr_en, illegal);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mul_ready: ready=%b want 1", ready);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_carry_chain();
    test_byte_sub();
    test_dadd();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_flag_priority();
    test_reset_mid_mul();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d results never arrived, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
